addr_scramble: RTL

Keyed, iterative address scrambler for the 64x64 face window (4096 pixels) of the 256x256 gray image. It maps a 12-bit in-window pixel address to a scrambled 12-bit address using an 8-round, 6/6-bit Feistel network keyed by a 16-bit key. The existing descrambler computes the exact inverse: same round keys, applied in reverse order. The image-scramble bench drives it once per face pixel and writes Face_scr[out_addr] = Face[in_addr].

---
 rtl/scramble_pkg.sv | 42 ++++
 rtl/addr_scramble_if.sv | 22 ++
 rtl/feistel_round.sv | 17 +
 rtl/addr_scramble.sv | 83 ++++++++
 4 files changed

// File: rtl/scramble_pkg.sv
// Shared constants, FSM encoding and key-schedule helpers for the 12-bit
// Feistel address scrambler and its descrambler.
package scramble_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned KEY_W  = 16;
    localparam int unsigned ROUNDS = 8;
    localparam int unsigned HALF_W = ADDR_W / 2;
    localparam int unsigned RCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [KEY_W-1:0] rotl16(input logic [KEY_W-1:0] x,
                                                 input int unsigned n);
        int unsigned s;
        s = n % KEY_W;
        if (s == 0) return x;
        return (x << s) | (x >> (KEY_W - s));
    endfunction

    function automatic logic [HALF_W-1:0] rotl6(input logic [HALF_W-1:0] x);
        return {x[HALF_W-2:0], x[HALF_W-1]};
    endfunction

    // Round r uses the low half-word of the key rotated left by 2r bits.
    function automatic logic [HALF_W-1:0] round_key(input logic [KEY_W-1:0]  kreg,
                                                    input logic [RCNT_W-1:0] r);
        logic [KEY_W-1:0] rot;
        rot = rotl16(kreg, 32'(r) * 32'd2);
        return rot[HALF_W-1:0];
    endfunction

    function automatic logic [HALF_W-1:0] feistel_f(input logic [HALF_W-1:0] r,
                                                    input logic [HALF_W-1:0] rk);
        return rotl6(r ^ rk);
    endfunction

endpackage

// File: rtl/addr_scramble_if.sv
// Request/result bundle between the image bench and the address scrambler.
interface addr_scramble_if;
    import scramble_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] in_addr;
    logic [KEY_W-1:0]  key;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output start, in_addr, key,
        input  busy, done, out_addr
    );

    modport slave (
        input  start, in_addr, key,
        output busy, done, out_addr
    );

endinterface

// File: rtl/feistel_round.sv
// One forward Feistel round on 6-bit halves: L' = R, R' = L ^ F(R, rk).
module feistel_round
    import scramble_pkg::*;
(
    input  logic [HALF_W-1:0] l,
    input  logic [HALF_W-1:0] r,
    input  logic [HALF_W-1:0] rk,
    output logic [HALF_W-1:0] l_new,
    output logic [HALF_W-1:0] r_new
);

    always_comb begin
        l_new = r;
        r_new = l ^ feistel_f(r, rk);
    end

endmodule

// File: rtl/addr_scramble.sv
// Iterative keyed address scrambler: one Feistel round per clock, result
// held in out_addr and flagged by a one-cycle done pulse.
module addr_scramble
    import scramble_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    addr_scramble_if.slave bus
);

    state_t              state;
    state_t              state_next;
    logic [RCNT_W-1:0]   rcnt;
    logic [HALF_W-1:0]   l_q;
    logic [HALF_W-1:0]   r_q;
    logic [HALF_W-1:0]   l_new;
    logic [HALF_W-1:0]   r_new;
    logic [HALF_W-1:0]   rk;
    logic [KEY_W-1:0]    kreg;
    logic [ADDR_W-1:0]   out_q;
    logic                accept;
    logic                last_round;

    // A new request is taken in IDLE and also in the DONE cycle.
    assign accept     = bus.start && (state == IDLE || state == DONE);
    assign last_round = (rcnt == RCNT_W'(ROUNDS - 1));
    assign rk         = round_key(kreg, rcnt);

    feistel_round u_round (
        .l     (l_q),
        .r     (r_q),
        .rk    (rk),
        .l_new (l_new),
        .r_new (r_new)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_round) state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state == RUN);
        bus.done = (state == DONE);
    end

    assign bus.out_addr = out_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt  <= '0;
            l_q   <= '0;
            r_q   <= '0;
            kreg  <= '0;
            out_q <= '0;
        end else if (accept) begin
            rcnt <= '0;
            l_q  <= bus.in_addr[ADDR_W-1:HALF_W];
            r_q  <= bus.in_addr[HALF_W-1:0];
            kreg <= bus.key;
        end else if (state == RUN) begin
            rcnt <= rcnt + 1'b1;
            l_q  <= l_new;
            r_q  <= r_new;
            // Last round output is taken unswapped.
            if (last_round) out_q <= {l_new, r_new};
        end
    end

endmodule
